// File: rtl/sdiv_pkg.sv
// Shared types and helpers for the radix-2 signed divider.
// Magnitudes are computed at a fixed 64-bit width and truncated by the caller.
package sdiv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    COMPUTE,
    FIX,
    DONE
  } state_t;

  localparam int DEF_WIDTH = 16;
  localparam int MAG_W     = 64;
  localparam int CNT_W     = $clog2(DEF_WIDTH + 1);

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  // |MIN| of a narrower operand survives because the caller sign-extends first.
  function automatic logic [MAG_W-1:0] abs_mag(input logic signed [MAG_W-1:0] v);
    return v[MAG_W-1] ? -v : v;
  endfunction

endpackage

// File: rtl/sdiv_ctrl.sv
// Divider sequencer: state register, iteration counter, rdy/busy flags.
// Issues one-cycle load/init/shift/fix enables to the datapath in sdiv_radix2.
module sdiv_ctrl
  import sdiv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic clk,
  input  logic rst_n,
  input  logic go,
  input  logic b_zero,
  output logic load_en,
  output logic init_en,
  output logic shift_en,
  output logic fix_en,
  output logic rdy,
  output logic busy
);

  localparam int CW = cnt_width(WIDTH);

  state_t         state_reg, state_next;
  logic [CW-1:0]  cnt_reg, cnt_next;
  logic           rdy_reg, rdy_next;
  logic           busy_reg, busy_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      rdy_reg   <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      rdy_reg   <= rdy_next;
      busy_reg  <= busy_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    rdy_next   = rdy_reg;
    busy_next  = busy_reg;
    load_en    = 1'b0;
    init_en    = 1'b0;
    shift_en   = 1'b0;
    fix_en     = 1'b0;
    case (state_reg)
      IDLE, DONE: begin
        if (go) begin
          load_en    = 1'b1;
          rdy_next   = 1'b0;
          busy_next  = 1'b1;
          state_next = INIT;
        end
      end
      INIT: begin
        init_en    = 1'b1;
        cnt_next   = CW'(WIDTH);
        state_next = b_zero ? FIX : COMPUTE;
      end
      COMPUTE: begin
        shift_en = 1'b1;
        cnt_next = cnt_reg - CW'(1);
        // Last of WIDTH iterations: counter is about to reach zero.
        if (cnt_reg == CW'(1)) begin
          state_next = FIX;
        end
      end
      FIX: begin
        fix_en     = 1'b1;
        rdy_next   = 1'b1;
        busy_next  = 1'b0;
        state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign rdy  = rdy_reg;
  assign busy = busy_reg;

endmodule

// File: rtl/sdiv_radix2.sv
// Signed radix-2 restoring divider, one quotient bit per clock, go/rdy handshake.
// Define SDIV_REM_EN to add the signed remainder output and its register.
module sdiv_radix2
  import sdiv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
`ifdef SDIV_REM_EN
  output logic [WIDTH-1:0] remainder,
`endif
  output logic             rdy,
  output logic             busy,
  output logic             div0,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] Q_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] Q_MAX = ~Q_MIN;

  logic load_en, init_en, shift_en, fix_en;
  logic b_zero;

  logic [WIDTH-1:0] a_mag_reg, b_mag_reg;
  logic [WIDTH:0]   r_reg;
  logic [WIDTH-1:0] q_reg;
  logic             neg_q_reg, neg_r_reg, ovf_pend_reg;
  logic [WIDTH-1:0] quotient_reg;
  logic             div0_reg, ovf_reg;

  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH+1:0] r_shift;
  logic             r_ge;
  logic             is_ovf;

  assign a_abs  = WIDTH'(abs_mag(MAG_W'(signed'(dividend))));
  assign b_abs  = WIDTH'(abs_mag(MAG_W'(signed'(divisor))));
  assign is_ovf = (dividend == Q_MIN) && (divisor == '1);
  assign b_zero = (b_mag_reg == '0);

  // Top bit of r_shift is always 0 in practice; kept so the full R register feeds the compare.
  assign r_shift = {r_reg, a_mag_reg[WIDTH-1]};
  assign r_ge    = (r_shift >= {2'b00, b_mag_reg});

  sdiv_ctrl #(
    .WIDTH(WIDTH)
  ) u_ctrl (
    .clk     (clk),
    .rst_n   (rst_n),
    .go      (go),
    .b_zero  (b_zero),
    .load_en (load_en),
    .init_en (init_en),
    .shift_en(shift_en),
    .fix_en  (fix_en),
    .rdy     (rdy),
    .busy    (busy)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_mag_reg    <= '0;
      b_mag_reg    <= '0;
      r_reg        <= '0;
      q_reg        <= '0;
      neg_q_reg    <= 1'b0;
      neg_r_reg    <= 1'b0;
      ovf_pend_reg <= 1'b0;
      quotient_reg <= '0;
      div0_reg     <= 1'b0;
      ovf_reg      <= 1'b0;
    end else begin
      if (load_en) begin
        a_mag_reg    <= a_abs;
        b_mag_reg    <= b_abs;
        neg_q_reg    <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
        neg_r_reg    <= dividend[WIDTH-1];
        ovf_pend_reg <= is_ovf;
        div0_reg     <= 1'b0;
        ovf_reg      <= 1'b0;
      end
      if (init_en) begin
        r_reg <= '0;
        q_reg <= '0;
      end
      if (shift_en) begin
        a_mag_reg <= {a_mag_reg[WIDTH-2:0], 1'b0};
        r_reg     <= r_ge ? (WIDTH+1)'(r_shift - {2'b00, b_mag_reg}) : r_shift[WIDTH:0];
        q_reg     <= {q_reg[WIDTH-2:0], r_ge};
      end
      if (fix_en) begin
        if (b_zero) begin
          quotient_reg <= neg_r_reg ? Q_MIN : Q_MAX;
          div0_reg     <= 1'b1;
        end else begin
          quotient_reg <= neg_q_reg ? -q_reg : q_reg;
          ovf_reg      <= ovf_pend_reg;
        end
      end
    end
  end

`ifdef SDIV_REM_EN
  logic [WIDTH-1:0] remainder_reg;

  // With a zero divisor no shifting happened, so a_mag_reg still holds |dividend|.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remainder_reg <= '0;
    end else if (fix_en) begin
      if (b_zero) begin
        remainder_reg <= neg_r_reg ? -a_mag_reg : a_mag_reg;
      end else begin
        remainder_reg <= neg_r_reg ? -r_reg[WIDTH-1:0] : r_reg[WIDTH-1:0];
      end
    end
  end

  assign remainder = remainder_reg;
`endif

  assign quotient = quotient_reg;
  assign div0     = div0_reg;
  assign ovf      = ovf_reg;

endmodule
